counter_sweep_ctrl: RTL

- Command-side initiator for the 8-bit parallel-load up/down counter: drives its load, En, D and value inputs and watches its OUT.
- Makes the counter sweep a programmed window [lo, hi] in one of three modes: up-wrap, down-wrap or ping-pong.
- Runs for a programmed number of passes, then stops the counter and pulses done.
- Sits between the register/command layer and the counter instance.

---
 rtl/counter_sweep_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/counter_sweep_ctrl.sv
// Sweeps an attached parallel-load up/down counter across [lo, hi] in up-wrap,
// down-wrap or ping-pong mode for a programmed number of passes.
module counter_sweep_ctrl #(
  parameter int N = 8,
  parameter int P = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         stop,
  input  logic [N-1:0] lo,
  input  logic [N-1:0] hi,
  input  logic [1:0]   mode,
  input  logic [P-1:0] passes,
  input  logic [N-1:0] cnt_in,
  output logic         load,
  output logic         En,
  output logic         D,
  output logic [N-1:0] value,
  output logic         busy,
  output logic         done,
  output logic         err
);

  typedef enum logic [1:0] {S_IDLE, S_PRELOAD, S_RUN} state_t;

  localparam logic [1:0] MD_UP   = 2'b00;
  localparam logic [1:0] MD_DOWN = 2'b01;
  localparam logic [1:0] MD_RSV  = 2'b11;

  state_t       r_state, w_next;
  logic [N-1:0] r_lo, r_hi;
  logic [1:0]   r_mode;
  logic [P-1:0] r_passes, r_pcnt;
  logic         r_dir, r_done, r_err;

  logic [N-1:0] w_end;
  logic [P-1:0] w_pinc;
  logic         w_hit, w_last, w_bad, w_accept, w_pass;

  assign w_end    = r_dir ? r_lo : r_hi;
  assign w_hit    = (cnt_in == w_end);
  assign w_pinc   = r_pcnt + 1'b1;
  assign w_last   = (r_passes != '0) && (w_pinc == r_passes);
  assign w_bad    = (lo > hi) || (mode == MD_RSV);
  assign w_accept = (r_state == S_IDLE) && start && !w_bad;
  // a pass is only counted when stop does not pre-empt the bound action
  assign w_pass   = (r_state == S_RUN) && !stop && w_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_next = S_PRELOAD;
      S_PRELOAD: w_next = stop ? S_IDLE : S_RUN;
      S_RUN:     if (stop || (w_hit && w_last)) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    load  = 1'b0;
    En    = 1'b0;
    D     = 1'b0;
    value = '0;
    case (r_state)
      S_PRELOAD: if (!stop) begin
        load  = 1'b1;
        En    = 1'b1;
        D     = r_dir;
        value = (r_mode == MD_DOWN) ? r_hi : r_lo;
      end
      S_RUN: if (!stop) begin
        En = 1'b1;
        D  = r_dir;
        if (w_hit) begin
          if (w_last) En = 1'b0;
          else begin
            case (r_mode)
              MD_UP:   begin load = 1'b1; value = r_lo; end
              MD_DOWN: begin load = 1'b1; value = r_hi; end
              default: begin
                D = ~r_dir;
                // one-value window: reload instead of stepping out of it
                if (r_lo == r_hi) begin load = 1'b1; value = r_lo; end
              end
            endcase
          end
        end
      end
      default: ;
    endcase
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign err  = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lo     <= '0;
      r_hi     <= '0;
      r_mode   <= '0;
      r_passes <= '0;
      r_pcnt   <= '0;
      r_dir    <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_err  <= (r_state == S_IDLE) && start && w_bad;
      r_done <= w_pass && w_last;
      if (w_accept) begin
        r_lo     <= lo;
        r_hi     <= hi;
        r_mode   <= mode;
        r_passes <= passes;
        r_pcnt   <= '0;
        r_dir    <= (mode == MD_DOWN);
      end else if (w_pass) begin
        r_pcnt <= w_pinc;
        if (r_mode != MD_UP && r_mode != MD_DOWN) r_dir <= ~r_dir;
      end
    end
  end

endmodule
